nurse_dispatch_arbiter: RTL

Shares a single nurse-response resource between N_BED bedside triage_core instances. Each bed reports its current triage state code. The arbiter offers the nurse to the most severe bed, breaking ties round-robin. It then tracks the acknowledge/done handshake, enforces a minimum service time, and raises an escalation alarm when an offer goes unanswered. It sits between the per-bed triage_core FSMs and the ward call panel.

---
 rtl/nurse_dispatch_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/nurse_dispatch_arbiter.sv
// Nurse dispatch arbiter: offers one nurse to the most severe bed (round-robin on ties),
// tracks the ACK/DONE handshake, holds a minimum service time and escalates unanswered offers.
module nurse_dispatch_arbiter #(
   parameter int N_BED       = 4,
   parameter int SERVICE_CYC = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [2*N_BED-1:0]   LVL,
   input  logic                 ACK,
   input  logic                 DONE,
   output logic [N_BED-1:0]     GNT,
   output logic                 GNT_VLD,
   output logic [1:0]           GNT_LVL,
   output logic                 BUSY,
   output logic                 ALARM
);

   localparam int IW = (N_BED > 1) ? $clog2(N_BED) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int SW = $clog2(SERVICE_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_OFFER, S_SERVE} state_t;

   state_t            state_q, state_d;
   logic [N_BED-1:0]  gnt_q, gnt_d;
   logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
   logic              vld_q, vld_d;
   logic [1:0]        gnt_lvl_q, gnt_lvl_d;
   logic              busy_q, busy_d;
   logic              alarm_q, alarm_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic [SW-1:0]     scnt_q, scnt_d;
   logic              done_lat_q, done_lat_d;

   logic [N_BED-1:0]  req;
   logic [1:0]        cur_lvl;
   logic [1:0]        others_max;
   logic [IW-1:0]     pick_ptr;
   logic [IW-1:0]     pick_to;

   // Scan beds from ptr+1 around to ptr; strict '>' keeps the first bed in RR order among equals.
   function automatic logic [IW-1:0] pick(input logic [2*N_BED-1:0] lv, input logic [IW-1:0] ptr);
      logic [IW-1:0] best;
      logic [1:0]    best_lvl;
      int            idx;
      best     = ptr;
      best_lvl = 2'b00;
      for (int k = 1; k <= N_BED; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_BED) idx = idx - N_BED;
         if (lv[2*idx +: 2] > best_lvl) begin
            best_lvl = lv[2*idx +: 2];
            best     = IW'(idx);
         end
      end
      return best;
   endfunction

   function automatic logic [N_BED-1:0] onehot(input logic [IW-1:0] idx);
      logic [N_BED-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   generate
      for (genvar gi = 0; gi < N_BED; gi++) begin : g_req
         assign req[gi] = |LVL[2*gi +: 2];
      end
   endgenerate

   assign cur_lvl  = LVL[2*gnt_idx_q +: 2];
   assign pick_ptr = pick(LVL, ptr_q);
   assign pick_to  = pick(LVL, gnt_idx_q);

   always_comb begin
      others_max = 2'b00;
      for (int i = 0; i < N_BED; i++) begin
         if (!gnt_q[i] && (LVL[2*i +: 2] > others_max)) others_max = LVL[2*i +: 2];
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_idx_d  = gnt_idx_q;
      vld_d      = vld_q;
      gnt_lvl_d  = gnt_lvl_q;
      busy_d     = busy_q;
      alarm_d    = alarm_q;
      ptr_d      = ptr_q;
      tcnt_d     = tcnt_q;
      scnt_d     = scnt_q;
      done_lat_d = done_lat_q;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d   = S_OFFER;
               gnt_idx_d = pick_ptr;
               gnt_d     = onehot(pick_ptr);
               vld_d     = 1'b1;
               gnt_lvl_d = LVL[2*pick_ptr +: 2];
               tcnt_d    = '0;
            end
         end
         S_OFFER: begin
            if (ACK) begin
               state_d    = S_SERVE;
               busy_d     = 1'b1;
               scnt_d     = '0;
               done_lat_d = 1'b0;
               alarm_d    = 1'b0;
               gnt_lvl_d  = cur_lvl;
            end else if (cur_lvl == 2'b00) begin
               tcnt_d = '0;
               if (|req) begin
                  gnt_idx_d = pick_ptr;
                  gnt_d     = onehot(pick_ptr);
                  gnt_lvl_d = LVL[2*pick_ptr +: 2];
               end else begin
                  state_d   = S_IDLE;
                  gnt_d     = '0;
                  vld_d     = 1'b0;
                  gnt_lvl_d = 2'b00;
               end
            end else if (others_max > cur_lvl) begin
               gnt_idx_d = pick_ptr;
               gnt_d     = onehot(pick_ptr);
               gnt_lvl_d = LVL[2*pick_ptr +: 2];
               tcnt_d    = '0;
            end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
               // Unanswered offer: the silent bed moves to the back of the tie order.
               alarm_d   = 1'b1;
               ptr_d     = gnt_idx_q;
               gnt_idx_d = pick_to;
               gnt_d     = onehot(pick_to);
               gnt_lvl_d = LVL[2*pick_to +: 2];
               tcnt_d    = '0;
            end else begin
               tcnt_d    = tcnt_q + 1'b1;
               gnt_lvl_d = cur_lvl;
            end
         end
         S_SERVE: begin
            gnt_lvl_d  = cur_lvl;
            done_lat_d = done_lat_q | DONE;
            if (scnt_q != SW'(SERVICE_CYC)) scnt_d = scnt_q + 1'b1;
            if (done_lat_q && (scnt_q >= SW'(SERVICE_CYC - 1))) begin
               state_d    = S_IDLE;
               gnt_d      = '0;
               vld_d      = 1'b0;
               busy_d     = 1'b0;
               gnt_lvl_d  = 2'b00;
               ptr_d      = gnt_idx_q;
               done_lat_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         gnt_q      <= '0;
         gnt_idx_q  <= '0;
         vld_q      <= 1'b0;
         gnt_lvl_q  <= 2'b00;
         busy_q     <= 1'b0;
         alarm_q    <= 1'b0;
         ptr_q      <= IW'(N_BED - 1);
         tcnt_q     <= '0;
         scnt_q     <= '0;
         done_lat_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         vld_q      <= vld_d;
         gnt_lvl_q  <= gnt_lvl_d;
         busy_q     <= busy_d;
         alarm_q    <= alarm_d;
         ptr_q      <= ptr_d;
         tcnt_q     <= tcnt_d;
         scnt_q     <= scnt_d;
         done_lat_q <= done_lat_d;
      end
   end

   assign GNT     = gnt_q;
   assign GNT_VLD = vld_q;
   assign GNT_LVL = gnt_lvl_q;
   assign BUSY    = busy_q;
   assign ALARM   = alarm_q;

endmodule
